bcd_countdown_timer: RTL and testbench

- Clocked MM:SS timer with four BCD digit outputs. It is the sequential, parametrised successor of the team's combinational seconds-to-MM:SS converter.
- Accepts a binary seconds preload and converts it to BCD over several cycles by iterative subtraction.
- Then counts down, or up, one step per prescaled tick, with start/pause control and a done pulse.
- Sits between the keypad/control logic and the 7-segment display driver.

---
 rtl/bcd_countdown_timer.sv | 215 +++++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD timer: binary preload converted by iterative subtraction, then up/down count.
// Define TIMER_AUTORELOAD_EN to reconvert the preload and keep running at the limit.
module bcd_countdown_timer #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int MAX_MIN     = 59,
  parameter int LOAD_W      = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LOAD_W-1:0] load_seconds,
  input  logic              start,
  input  logic              pause,
  input  logic              count_up,
  output logic [3:0]        minutes_tens,
  output logic [3:0]        minutes_units,
  output logic [3:0]        seconds_tens,
  output logic [3:0]        seconds_units,
  output logic              busy,
  output logic              running,
  output logic              done
);

  localparam int PW = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] TERM = PW'(CLK_FREQ_HZ - 1);
  localparam logic [LOAD_W-1:0] LIMIT_S = LOAD_W'(MAX_MIN * 60 + 59);
  localparam logic [LOAD_W-1:0] SIXTY = LOAD_W'(60);
  localparam logic [LOAD_W-1:0] TEN = LOAD_W'(10);
  localparam logic [3:0] LIM_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] LIM_MU = 4'(MAX_MIN % 10);

  typedef enum logic [2:0] {
    IDLE, CONVERT, PAUSED, RUNNING, DONE
  } state_t;

  state_t state, state_d;
  logic [LOAD_W-1:0] rem, rem_d, clamped;
  logic [3:0] mt, mu, st, su;
  logic [3:0] mt_d, mu_d, st_d, su_d;
  logic [3:0] dmt, dmu, dst, dsu;
  logic [3:0] umt, umu, ust, usu;
  logic [PW-1:0] presc, presc_d;
  logic dir, dir_d;
  logic done_q, done_d;
  logic tick, hit, at_zero, at_max, dn_hit, up_hit;
`ifdef TIMER_AUTORELOAD_EN
  logic [LOAD_W-1:0] stored, stored_d;
  logic reload, reload_d;
`endif

  assign clamped = (load_seconds > LIMIT_S) ? LIMIT_S : load_seconds;
  assign tick = (state == RUNNING) && (presc == TERM);
  assign at_zero = ({mt, mu, st, su} == 16'h0000);
  assign at_max = (mt == LIM_MT) && (mu == LIM_MU) &&
                  (st == 4'd5) && (su == 4'd9);

  // One-step neighbours of the current value, with BCD borrow/carry chains
  always_comb begin
    {dmt, dmu, dst, dsu} = {mt, mu, st, su};
    if (su != 4'd0) dsu = su - 4'd1;
    else begin
      dsu = 4'd9;
      if (st != 4'd0) dst = st - 4'd1;
      else begin
        dst = 4'd5;
        if (mu != 4'd0) dmu = mu - 4'd1;
        else begin
          dmu = 4'd9;
          dmt = mt - 4'd1;
        end
      end
    end
    {umt, umu, ust, usu} = {mt, mu, st, su};
    if (su != 4'd9) usu = su + 4'd1;
    else begin
      usu = 4'd0;
      if (st != 4'd5) ust = st + 4'd1;
      else begin
        ust = 4'd0;
        if (mu != 4'd9) umu = mu + 4'd1;
        else begin
          umu = 4'd0;
          umt = mt + 4'd1;
        end
      end
    end
    dn_hit = ({dmt, dmu, dst, dsu} == 16'h0000);
    up_hit = (umt == LIM_MT) && (umu == LIM_MU) &&
             (ust == 4'd5) && (usu == 4'd9);
  end

  always_comb begin
    state_d = state;
    rem_d   = rem;
    {mt_d, mu_d, st_d, su_d} = {mt, mu, st, su};
    presc_d = presc;
    dir_d   = dir;
    done_d  = 1'b0;
    hit     = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    stored_d = stored;
    reload_d = reload;
`endif
    if (load) begin
      rem_d   = clamped;
      {mt_d, mu_d, st_d, su_d} = 16'h0000;
      presc_d = '0;
      state_d = CONVERT;
`ifdef TIMER_AUTORELOAD_EN
      stored_d = clamped;
      reload_d = 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: ;
        CONVERT: begin
          if (rem >= SIXTY) begin
            rem_d = rem - SIXTY;
            if (mu == 4'd9) begin
              mu_d = 4'd0;
              mt_d = mt + 4'd1;
            end else begin
              mu_d = mu + 4'd1;
            end
          end else if (rem >= TEN) begin
            rem_d = rem - TEN;
            st_d  = st + 4'd1;
          end else begin
            su_d    = rem[3:0];
            state_d = PAUSED;
`ifdef TIMER_AUTORELOAD_EN
            if (reload) state_d = RUNNING;
            reload_d = 1'b0;
`endif
          end
        end
        PAUSED: begin
          if (!pause && start) begin
            dir_d = count_up;
            if (count_up ? at_max : at_zero) hit = 1'b1;
            else state_d = RUNNING;
          end
        end
        RUNNING: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            presc_d = '0;
            if (dir) {mt_d, mu_d, st_d, su_d} = {umt, umu, ust, usu};
            else {mt_d, mu_d, st_d, su_d} = {dmt, dmu, dst, dsu};
            hit = dir ? up_hit : dn_hit;
          end else begin
            presc_d = presc + 1'b1;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
      if (hit) begin
        done_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
        // Periodic mode: rebuild the preload and resume in the same direction
        state_d  = CONVERT;
        rem_d    = stored;
        {mt_d, mu_d, st_d, su_d} = 16'h0000;
        presc_d  = '0;
        reload_d = 1'b1;
`else
        state_d = DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rem    <= '0;
      mt     <= 4'd0;
      mu     <= 4'd0;
      st     <= 4'd0;
      su     <= 4'd0;
      presc  <= '0;
      dir    <= 1'b0;
      done_q <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      stored <= '0;
      reload <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      rem    <= rem_d;
      mt     <= mt_d;
      mu     <= mu_d;
      st     <= st_d;
      su     <= su_d;
      presc  <= presc_d;
      dir    <= dir_d;
      done_q <= done_d;
`ifdef TIMER_AUTORELOAD_EN
      stored <= stored_d;
      reload <= reload_d;
`endif
    end
  end

  assign minutes_tens  = mt;
  assign minutes_units = mu;
  assign seconds_tens  = st;
  assign seconds_units = su;
  assign busy    = (state == CONVERT);
  assign running = (state == RUNNING);
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with a 4-cycle tick.
// Build with TIMER_AUTORELOAD_EN to exercise the periodic mode.
module tb_bcd_countdown_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [12:0] load_seconds = '0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic count_up = 1'b0;
  logic [3:0] minutes_tens, minutes_units;
  logic [3:0] seconds_tens, seconds_units;
  logic busy, running, done;
  logic [15:0] dig;
  int n_cmp = 0;
  int n_bad = 0;
  int n;

  bcd_countdown_timer #(
    .CLK_FREQ_HZ(4),
    .MAX_MIN(59),
    .LOAD_W(13)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_seconds(load_seconds),
    .start(start),
    .pause(pause),
    .count_up(count_up),
    .minutes_tens(minutes_tens),
    .minutes_units(minutes_units),
    .seconds_tens(seconds_tens),
    .seconds_units(seconds_units),
    .busy(busy),
    .running(running),
    .done(done)
  );

  always #5 clk = ~clk;

  assign dig = {minutes_tens, minutes_units, seconds_tens, seconds_units};

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    load_seconds = 13'(v);
    cyc(1);
    load = 1'b0;
  endtask

  // Count CONVERT cycles, bounded so a stuck busy still ends the run
  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cyc(1);
      cnt++;
    end
  endtask

  task automatic go(input logic up);
    count_up = up;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("rst_dig", int'(dig), 'h0000);
    chk("rst_flags", int'({busy, running, done}), 0);

    do_load(125);
    chk("ld125_busy", int'(busy), 1);
    wait_busy(n);
    chk("ld125_cycles", n, 3);
    chk("ld125_dig", int'(dig), 'h0205);
    chk("ld125_flags", int'({busy, running, done}), 0);

    do_load(6000);
    wait_busy(n);
    chk("clamp_cycles", n, 65);
    chk("clamp_dig", int'(dig), 'h5959);

    do_load(600);
    wait_busy(n);
    chk("ld600_cycles", n, 11);
    go(1'b0);
    chk("dn_running", int'(running), 1);
    cyc(3);
    chk("dn_pretick", int'(dig), 'h1000);
    cyc(1);
    chk("dn_borrow", int'(dig), 'h0959);

    do_load(1);
    wait_busy(n);
    go(1'b0);
    cyc(4);
    chk("dn_zero", int'(dig), 'h0000);
    chk("dn_done", int'({running, done}), 'b01);
    cyc(1);
    chk("dn_done_1cyc", int'(done), 0);

    do_load(59);
    wait_busy(n);
    chk("ld59_cycles", n, 6);
    go(1'b1);
    cyc(4);
    chk("up_carry", int'(dig), 'h0100);

    do_load(0);
    wait_busy(n);
    go(1'b0);
    chk("zero_start_done", int'({running, done}), 'b01);
    cyc(1);
    chk("zero_start_pulse", int'(done), 0);

    do_load(600);
    wait_busy(n);
    go(1'b0);
    cyc(2);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    chk("pause_run", int'(running), 0);
    cyc(10);
    chk("pause_hold", int'(dig), 'h1000);
    go(1'b0);
    cyc(1);
    chk("resume_pre", int'(dig), 'h1000);
    cyc(1);
    chk("resume_tick", int'(dig), 'h0959);
    pause = 1'b1;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    pause = 1'b0;
    chk("start_pause_both", int'(running), 0);

    go(1'b0);
    cyc(1);
    do_load(125);
    chk("ld_in_run", int'({busy, running}), 'b10);
    wait_busy(n);
    chk("ld_in_run_dig", int'(dig), 'h0205);

    do_load(6000);
    cyc(5);
    reset = 1'b1;
    #1;
    chk("rst_conv_dig", int'(dig), 'h0000);
    chk("rst_conv_flags", int'({busy, running, done}), 0);
    cyc(1);
    reset = 1'b0;

    do_load(600);
    wait_busy(n);
    go(1'b0);
    cyc(5);
    reset = 1'b1;
    #1;
    chk("rst_run_dig", int'(dig), 'h0000);
    chk("rst_run_flags", int'({busy, running, done}), 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);

`ifdef TIMER_AUTORELOAD_EN
    do_load(2);
    wait_busy(n);
    go(1'b0);
    n = 0;
    while (!done && n < 50) begin
      cyc(1);
      n++;
    end
    chk("ar_first", n, 8);
    n = 0;
    cyc(1);
    n++;
    while (!done && n < 50) begin
      cyc(1);
      n++;
    end
    chk("ar_period", n, 9);
    chk("ar_running", int'(running), 0);
`else
    do_load(3598);
    wait_busy(n);
    go(1'b1);
    cyc(3);
    chk("up_prelim", int'(dig), 'h5958);
    cyc(1);
    chk("up_limit", int'(dig), 'h5959);
    chk("up_done", int'({running, done}), 'b01);
    cyc(1);
    chk("up_done_1cyc", int'(done), 0);
    go(1'b0);
    cyc(8);
    chk("done_hold", int'(dig), 'h5959);
    chk("done_flags", int'({busy, running, done}), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
